// File: rtl/sigmoid_sched.sv
// Round-robin scheduler sharing one fixed-latency sigmoid unit among several requesters.
// Results are buffered in a credit-protected FIFO so output backpressure never stalls the unit.
module sigmoid_sched #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned SigLat   = 1,
  parameter int unsigned OutDepth = 4,
  parameter int unsigned IdW      = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
  input  logic [32*NumReq-1:0] req_data_i,
  input  logic [NumReq-1:0]   req_bypass_i,
  output logic [31:0]         sig_data_in_o,
  output logic                sig_bypass_o,
  input  logic [31:0]         sig_data_out_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_data_o,
  output logic [IdW-1:0]      rsp_id_o,
  output logic                busy_o
);

  localparam int unsigned PtrW = (OutDepth > 1) ? $clog2(OutDepth) : 1;
  localparam int unsigned CntW = $clog2(OutDepth + 1);

  logic [IdW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [SigLat-1:0]          vld_q, vld_d;
  logic [SigLat-1:0][IdW-1:0] id_q, id_d;
  logic [31:0]                mem_data_q [OutDepth];
  logic [IdW-1:0]             mem_id_q [OutDepth];
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            fifo_cnt_q, fifo_cnt_d;

  logic           gnt, credit_ok, push, pop;
  logic [IdW-1:0] gnt_idx;
  int unsigned    inflight_cnt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == OutDepth - 1) ? '0 : p + 1'b1;
  endfunction

  // Credit uses registered counts only, so rsp_ready never reaches req_ready.
  always_comb begin
    int unsigned    idx;
    logic [IdW-1:0] cand;
    idx          = 0;
    cand         = '0;
    gnt          = 1'b0;
    gnt_idx      = '0;
    inflight_cnt = 0;
    for (int unsigned i = 0; i < SigLat; i++) inflight_cnt += 32'(vld_q[i]);
    credit_ok = (32'(fifo_cnt_q) + inflight_cnt) < OutDepth;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NumReq) idx -= NumReq;
      cand = IdW'(idx);
      if (!gnt && req_valid_i[cand]) begin
        gnt     = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = gnt && credit_ok && reset_ni;
  end

  always_comb begin
    req_ready_o   = '0;
    sig_data_in_o = '0;
    sig_bypass_o  = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (gnt && gnt_idx == IdW'(i)) begin
        req_ready_o[i] = 1'b1;
        sig_data_in_o  = req_data_i[32*i +: 32];
        sig_bypass_o   = req_bypass_i[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt) rr_ptr_d = (32'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + 1'b1;
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = gnt;
    id_d[0]  = gnt_idx;
    for (int unsigned i = 1; i < SigLat; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  assign push = vld_q[SigLat-1];
  assign pop  = rsp_valid_o && rsp_ready_i;

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr_q   <= '0;
      vld_q      <= '0;
      id_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      vld_q      <= vld_d;
      id_q       <= id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= sig_data_out_i;
      mem_id_q[wr_ptr_q]   <= id_q[SigLat-1];
    end
  end

  assign rsp_valid_o = (fifo_cnt_q != '0);
  assign rsp_data_o  = rsp_valid_o ? mem_data_q[rd_ptr_q] : '0;
  assign rsp_id_o    = rsp_valid_o ? mem_id_q[rd_ptr_q] : '0;
  assign busy_o      = (|vld_q) || rsp_valid_o;

  full_push_a: assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(push && 32'(fifo_cnt_q) == OutDepth));

endmodule
